// File: rtl/fsm_pkg.sv
// Shared definitions for the key conditioning logic: one-hot debounce
// states and the default stability window.
package fsm_pkg;

  // About 10 ms at a 50 MHz system clock.
  localparam int DB_DEFAULT_CYCLES = 500000;

  typedef enum logic [3:0] {
    DB_IDLE       = 4'b0001,
    DB_PRESS_FILT = 4'b0010,
    DB_HELD       = 4'b0100,
    DB_REL_FILT   = 4'b1000
  } db_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for asynchronous pin inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces one mechanical key into a clean level plus press/release
// strobes for the downstream control FSM.
module key_debounce
  import fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  // A window shorter than two cycles cannot filter anything, and the
  // counter must be able to reach the last count without wrapping.
  if (DEBOUNCE_CYCLES < 2) begin : g_min_check
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end
  if (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_max_check
    $error("key_debounce: DEBOUNCE_CYCLES must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             keyPol;
  logic             keySync;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Polarity is corrected ahead of the synchronizer so that its reset
  // value always means "released".
  assign keyPol = key_raw_i ^ ACTIVE_LOW;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (keyPol),
    .q_o   (keySync)
  );

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DB_IDLE;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic: a new level is accepted only after it has been seen
  // for DEBOUNCE_CYCLES consecutive synced cycles; any reversal restarts.
  always_comb begin
    state_d   = DB_IDLE;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (keySync) begin
          state_d = DB_PRESS_FILT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = DB_IDLE;
        end
      end
      DB_PRESS_FILT: begin
        if (!keySync) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          press_d = 1'b1;
        end else begin
          state_d = DB_PRESS_FILT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DB_HELD: begin
        if (!keySync) begin
          state_d = DB_REL_FILT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = DB_HELD;
        end
      end
      DB_REL_FILT: begin
        if (keySync) begin
          state_d = DB_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DB_IDLE;
          release_d = 1'b1;
        end else begin
          state_d = DB_REL_FILT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_IDLE;
      end
    endcase
    key_d = (state_d == DB_HELD) || (state_d == DB_REL_FILT);
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with a 4-cycle window, covering both
// input polarities.
module tb_key_debounce;

  typedef struct {
    bit isPress;
    int cyc;
  } expT;

  logic clk;
  logic rst;
  logic rawA, keyA, pressA, releaseA;
  logic rawB, keyB, pressB, releaseB;

  int cycle;
  int vectors;
  int miscompares;
  expT qA[$];
  expT qB[$];

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4),
    .ACTIVE_LOW      (1'b0)
  ) dutA (
    .clk_i     (clk),
    .rst_i     (rst),
    .key_raw_i (rawA),
    .key_o     (keyA),
    .press_o   (pressA),
    .release_o (releaseA)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4),
    .ACTIVE_LOW      (1'b1)
  ) dutB (
    .clk_i     (clk),
    .rst_i     (rst),
    .key_raw_i (rawB),
    .key_o     (keyB),
    .press_o   (pressB),
    .release_o (releaseB)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp expected strobes.
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit toB, input logic val, input bit expectEvent,
                               input bit isPress);
    expT e;
    if (toB) rawB = val;
    else     rawA = val;
    if (expectEvent) begin
      e.isPress = isPress;
      e.cyc     = cycle + 6;
      if (toB) qB.push_back(e);
      else     qA.push_back(e);
    end
  endtask

  task automatic expectAfterReset(input int relCycle);
    expT e;
    e.isPress = 1'b1;
    e.cyc     = relCycle + 6;
    qA.push_back(e);
  endtask

  // Monitor for the active-high instance: every strobe must match the head
  // of its queue in kind, cycle and debounced level.
  always @(negedge clk) begin
    expT e;
    if (!rst) begin
      if (pressA && releaseA) checkOutput("A_both_strobes", 1, 0);
      if (pressA || releaseA) begin
        if (qA.size() == 0) begin
          checkOutput("A_unexpected_strobe", int'(pressA) * 2 + int'(releaseA), 0);
        end else begin
          e = qA.pop_front();
          checkOutput("A_strobe_kind", int'(pressA), int'(e.isPress));
          checkOutput("A_strobe_cycle", cycle, e.cyc);
          checkOutput("A_strobe_level", int'(keyA), int'(e.isPress));
        end
      end
    end
  end

  // Monitor for the active-low instance.
  always @(negedge clk) begin
    expT e;
    if (!rst) begin
      if (pressB && releaseB) checkOutput("B_both_strobes", 1, 0);
      if (pressB || releaseB) begin
        if (qB.size() == 0) begin
          checkOutput("B_unexpected_strobe", int'(pressB) * 2 + int'(releaseB), 0);
        end else begin
          e = qB.pop_front();
          checkOutput("B_strobe_kind", int'(pressB), int'(e.isPress));
          checkOutput("B_strobe_cycle", cycle, e.cyc);
          checkOutput("B_strobe_level", int'(keyB), int'(e.isPress));
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    rawA = 1'b1;
    rawB = 1'b1;

    // Reset held with the key pressed.
    waitEdges(3);
    checkOutput("rst_keyA", int'(keyA), 0);
    checkOutput("rst_pressA", int'(pressA), 0);
    checkOutput("rst_releaseA", int'(releaseA), 0);
    checkOutput("rst_keyB", int'(keyB), 0);
    rst = 1'b0;
    expectAfterReset(cycle);
    waitEdges(10);
    checkOutput("post_rst_keyA", int'(keyA), 1);
    checkOutput("post_rst_drainA", qA.size(), 0);

    // Asynchronous reset while held clears the level without an edge.
    #2 rst = 1'b1;
    #1 checkOutput("async_rst_held_keyA", int'(keyA), 0);
    waitEdges(1);
    rst = 1'b0;
    expectAfterReset(cycle);
    waitEdges(10);
    checkOutput("requal_held_keyA", int'(keyA), 1);

    // Clean release, then clean press with one-cycle strobe.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitEdges(10);
    checkOutput("release_keyA", int'(keyA), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitEdges(6);
    checkOutput("press_e6_keyA", int'(keyA), 1);
    checkOutput("press_e6_pressA", int'(pressA), 1);
    waitEdges(1);
    checkOutput("press_e7_pressA", int'(pressA), 0);
    waitEdges(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitEdges(10);

    // Three-cycle glitch rejected; four-cycle pulse accepted.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitEdges(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(10);
    checkOutput("glitch3_keyA", int'(keyA), 0);
    checkOutput("glitch3_drainA", qA.size(), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitEdges(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitEdges(10);
    checkOutput("pulse4_drainA", qA.size(), 0);

    // Release bounce: 0,0,1 then steady 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitEdges(4);
    checkOutput("bounce_still_keyA", int'(keyA), 1);
    waitEdges(6);
    checkOutput("bounce_done_keyA", int'(keyA), 0);

    // Asynchronous reset in the middle of press filtering.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitEdges(4);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst_pf_keyA", int'(keyA), 0);
    checkOutput("async_rst_pf_pressA", int'(pressA), 0);
    waitEdges(1);
    rst = 1'b0;
    expectAfterReset(cycle);
    waitEdges(5);
    checkOutput("requal_e5_keyA", int'(keyA), 0);
    waitEdges(5);
    checkOutput("requal_pf_keyA", int'(keyA), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitEdges(10);

    // Active-low instance: pin low is a press.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitEdges(10);
    checkOutput("al_press_keyB", int'(keyB), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    waitEdges(10);
    checkOutput("al_release_keyB", int'(keyB), 0);

    checkOutput("final_drainA", qA.size(), 0);
    checkOutput("final_drainB", qB.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
